// File: rtl/bcd_seq_conv_pkg.sv
// Shared constants and state encoding for the iterative binary-to-BCD
// converter (double dabble, one input bit per clock).
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  // A digit >= 5 would reach >= 10 after the next shift, so it is
  // pre-corrected by +3 to force the carry into the next digit.
  localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] ADD3_VAL    = 4'd3;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_seq_conv_if.sv
// Handshake and data bundle between a requester and the BCD converter.
interface bcd_seq_conv_if #(
  parameter int BIN_W  = 15,
  parameter int DIGITS = 4
) ();

  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;

  // Requester side: issues start/bin, observes status and result.
  modport master (
    output start, bin,
    input  busy, done, bcd, ovf
  );

  // Converter side.
  modport slave (
    input  start, bin,
    output busy, done, bcd, ovf
  );

endinterface

// File: rtl/bcd_seq_conv_add3.sv
// Single-digit double-dabble correction: digits >= 5 get +3 before the shift.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  // Largest corrected value is 9+3=12, which still fits in one digit.
  assign dout = (din >= ADD3_THRESH) ? din + ADD3_VAL : din;

endmodule

// File: rtl/bcd_seq_conv.sv
// Iterative binary-to-BCD converter. One input bit is consumed per clock;
// the result and overflow flag are registered and held between done pulses.
module bcd_seq_conv
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 15,
  parameter int DIGITS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  bcd_seq_conv_if.slave bus
);

  localparam int SCR_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   sh_q;
  logic [SCR_W-1:0]   scr_q;
  logic               ovf_acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SCR_W-1:0]   bcd_q;
  logic               ovf_q;
  logic               done_q;

  logic [SCR_W-1:0]   scr_corr;
  logic [SCR_W-1:0]   scr_shift;
  logic [BIN_W-1:0]   sh_shift;
  logic               exit_bit;
  logic               load;
  logic               step;
  logic               last;

  // Per-digit correction of the scratch digits ahead of each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scr_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (scr_corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Shift the corrected digits and the remaining binary bits as one word;
  // the bit falling off the top digit marks a value too large for DIGITS.
  always_comb begin
    {scr_shift, sh_shift} = {scr_corr, sh_q} << 1;
    exit_bit              = scr_corr[SCR_W-1];
  end

  // Next-state and control decode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        step = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Conversion datapath, result registers and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these are plain flops (not a memory array), so all of them are
    // cleared by reset, including scratch state that a restart overwrites.
    if (!rst_n) begin
      sh_q      <= '0;
      scr_q     <= '0;
      ovf_acc_q <= 1'b0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= last;
      if (load) begin
        sh_q      <= bus.bin;
        scr_q     <= '0;
        ovf_acc_q <= 1'b0;
        cnt_q     <= CNT_W'(BIN_W);
      end else if (step) begin
        sh_q      <= sh_shift;
        scr_q     <= scr_shift;
        ovf_acc_q <= ovf_acc_q | exit_bit;
        cnt_q     <= cnt_q - CNT_W'(1);
      end
      if (last) begin
        bcd_q <= scr_shift;
        ovf_q <= ovf_acc_q | exit_bit;
      end
    end
  end

  assign bus.busy = (state_q == CONV);
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Self-checking bench for bcd_seq_conv: directed table for the default
// configuration, hand-written handshake/reset sequences, and randomized
// sweeps of two other configurations against a decimal reference model.
module tb_bcd_seq_conv;

  localparam int LAT_BOUND = 60;

  logic clk;
  logic rst_n;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_seq_conv_if #(.BIN_W(15), .DIGITS(4)) a_if ();
  bcd_seq_conv_if #(.BIN_W(8),  .DIGITS(3)) b_if ();
  bcd_seq_conv_if #(.BIN_W(20), .DIGITS(6)) c_if ();

  bcd_seq_conv #(.BIN_W(15), .DIGITS(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  bcd_seq_conv #(.BIN_W(8),  .DIGITS(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
  bcd_seq_conv #(.BIN_W(20), .DIGITS(6)) dut_c (.clk(clk), .rst_n(rst_n), .bus(c_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Decimal reference: low `digits` decimal digits of v, packed 4 bits each.
  function automatic logic [23:0] ref_bcd(input longint unsigned v, input int digits);
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input longint unsigned v, input int digits);
    longint unsigned lim;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    return (v >= lim);
  endfunction

  // One conversion on the 15/4 instance; returns edges-to-done and busy cycles.
  task automatic run_a(input logic [14:0] v, output int lat, output int busy_n);
    @(negedge clk);
    a_if.start = 1'b1;
    a_if.bin   = v;
    @(posedge clk);
    #1;
    a_if.start = 1'b0;
    a_if.bin   = ~v;
    lat    = 0;
    busy_n = 0;
    while (!a_if.done && lat < LAT_BOUND) begin
      if (a_if.busy) busy_n++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_b(input logic [7:0] v, output int lat);
    @(negedge clk);
    b_if.start = 1'b1;
    b_if.bin   = v;
    @(posedge clk);
    #1;
    b_if.start = 1'b0;
    lat = 0;
    while (!b_if.done && lat < LAT_BOUND) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_c(input logic [19:0] v, output int lat);
    @(negedge clk);
    c_if.start = 1'b1;
    c_if.bin   = v;
    @(posedge clk);
    #1;
    c_if.start = 1'b0;
    lat = 0;
    while (!c_if.done && lat < LAT_BOUND) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  typedef struct {
    logic [14:0] bin;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat;
    int busy_n;

    vecs[0] = '{bin: 15'd2000,  bcd: 16'h2000, ovf: 1'b0};
    vecs[1] = '{bin: 15'd0,     bcd: 16'h0000, ovf: 1'b0};
    vecs[2] = '{bin: 15'd9999,  bcd: 16'h9999, ovf: 1'b0};
    vecs[3] = '{bin: 15'd32767, bcd: 16'h2767, ovf: 1'b1};
    vecs[4] = '{bin: 15'd10000, bcd: 16'h0000, ovf: 1'b1};
    vecs[5] = '{bin: 15'd99,    bcd: 16'h0099, ovf: 1'b0};
    vecs[6] = '{bin: 15'd12345, bcd: 16'h2345, ovf: 1'b1};

    rst_n      = 1'b0;
    a_if.start = 1'b0;  a_if.bin = '0;
    b_if.start = 1'b0;  b_if.bin = '0;
    c_if.start = 1'b0;  c_if.bin = '0;

    // Reset state.
    #23;
    check("reset_busy", a_if.busy, 0);
    check("reset_done", a_if.done, 0);
    check("reset_bcd",  a_if.bcd,  0);
    check("reset_ovf",  a_if.ovf,  0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table on the default configuration.
    for (int i = 0; i < 7; i++) begin
      run_a(vecs[i].bin, lat, busy_n);
      check($sformatf("vec%0d_latency", i), lat, 15);
      check($sformatf("vec%0d_busy_cycles", i), busy_n, 15);
      check($sformatf("vec%0d_bcd", i), a_if.bcd, vecs[i].bcd);
      check($sformatf("vec%0d_ovf", i), a_if.ovf, vecs[i].ovf);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_one_cycle", i), a_if.done, 0);
      check($sformatf("vec%0d_bcd_hold", i), a_if.bcd, vecs[i].bcd);
    end

    // Back-to-back with start held high; bin changes mid-conversion ignored.
    @(negedge clk);
    a_if.start = 1'b1;
    a_if.bin   = 15'd1234;
    @(posedge clk);
    #1;
    a_if.bin = 15'd5678;
    lat = 0;
    while (!a_if.done && lat < LAT_BOUND) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("b2b_first_latency", lat, 15);
    check("b2b_first_bcd", a_if.bcd, 16'h1234);
    @(posedge clk);
    #1;
    check("b2b_accept_on_done", a_if.busy, 1);
    a_if.bin = 15'd1111;
    lat = 1;
    while (!a_if.done && lat < LAT_BOUND) begin
      @(posedge clk);
      #1;
      lat++;
    end
    a_if.start = 1'b0;
    check("b2b_done_spacing", lat, 16);
    check("b2b_second_bcd", a_if.bcd, 16'h5678);
    check("b2b_second_ovf", a_if.ovf, 0);
    repeat (2) @(posedge clk);
    #1;
    check("b2b_idle_after", a_if.busy, 0);

    // Reset in the middle of a conversion.
    @(negedge clk);
    a_if.start = 1'b1;
    a_if.bin   = 15'd4321;
    @(posedge clk);
    #1;
    a_if.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", a_if.busy, 0);
    check("midrst_done", a_if.done, 0);
    check("midrst_bcd",  a_if.bcd,  0);
    check("midrst_ovf",  a_if.ovf,  0);
    @(negedge clk);
    rst_n = 1'b1;
    busy_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (a_if.done || a_if.busy) busy_n++;
    end
    check("midrst_no_done", busy_n, 0);
    run_a(15'd4321, lat, busy_n);
    check("after_rst_latency", lat, 15);
    check("after_rst_bcd", a_if.bcd, 16'h4321);
    check("after_rst_ovf", a_if.ovf, 0);

    // Randomized sweep, BIN_W=8 / DIGITS=3.
    for (int i = 0; i < 20; i++) begin
      logic [7:0] v;
      v = (i == 0) ? 8'd0 : (i == 1) ? 8'd255 : 8'($urandom);
      run_b(v, lat);
      check($sformatf("b_lat_%0d", v), lat, 8);
      check($sformatf("b_bcd_%0d", v), b_if.bcd, ref_bcd(64'(v), 3) & 24'hfff);
      check($sformatf("b_ovf_%0d", v), b_if.ovf, ref_ovf(64'(v), 3));
    end

    // Randomized sweep, BIN_W=20 / DIGITS=6.
    for (int i = 0; i < 20; i++) begin
      logic [19:0] v;
      v = (i == 0) ? 20'd0 : (i == 1) ? 20'hfffff : 20'($urandom);
      run_c(v, lat);
      check($sformatf("c_lat_%0d", v), lat, 20);
      check($sformatf("c_bcd_%0d", v), c_if.bcd, ref_bcd(64'(v), 6));
      check($sformatf("c_ovf_%0d", v), c_if.ovf, ref_ovf(64'(v), 6));
    end

    // Randomized sweep of the default configuration, including overflow.
    for (int i = 0; i < 20; i++) begin
      logic [14:0] v;
      v = 15'($urandom);
      run_a(v, lat, busy_n);
      check($sformatf("a_bcd_%0d", v), a_if.bcd, ref_bcd(64'(v), 4) & 24'hffff);
      check($sformatf("a_ovf_%0d", v), a_if.ovf, ref_ovf(64'(v), 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
